fetch_unit: RTL

//  Parametrised instruction-fetch stage with redirect, back-pressure and an instruction queue.
//  It drives a synchronous instruction-memory read port (1-cycle read latency).
//  It buffers returned words in a DEPTH-entry FIFO and hands {pc, npc, instr} to decode over valid/ready.
//  A 2-bit redirect source (00 seq, 01 J, 10 I, 11 return) retargets the PC and flushes everything younger.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle synchronous imem port, buffers returned
// words in a DEPTH-entry queue and presents {pc, npc, instr} to decode over valid/ready.
module fetch_unit #(
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(1),
    parameter int unsigned        DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         redirect_src,
    input  logic [ADDR_W-1:0]  j_target,
    input  logic [ADDR_W-1:0]  i_target,
    input  logic [ADDR_W-1:0]  ret_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_npc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = INSTR_W + 2 * ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]  q_mem_q [DEPTH];
    logic [ENT_W-1:0]  q_mem_d [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    always_comb begin
        redirect = (redirect_src != 2'b00);
        case (redirect_src)
            2'b01:   target = j_target;
            2'b10:   target = i_target;
            2'b11:   target = ret_target;
            default: target = pc_q;
        endcase

        // The outstanding read holds a slot, so a response can always be pushed.
        credit_ok = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
        imem_req  = rst_n && !redirect && credit_ok;
        imem_addr = pc_q;

        head      = q_mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_instr = head[ENT_W-1 -: INSTR_W];
        out_pc    = head[2*ADDR_W-1 -: ADDR_W];
        out_npc   = head[ADDR_W-1:0];

        push = inflight_q;
        pop  = out_valid && out_ready;
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        req_addr_d = req_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        q_mem_d    = q_mem_q;

        if (redirect) begin
            // Flush: the response currently returning belongs to the old path.
            pc_d       = target;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                pc_d       = pc_q + PC_STEP;
                req_addr_d = pc_q;
            end
            if (push) begin
                q_mem_d[wr_ptr_q] = {imem_rdata, req_addr_q, req_addr_q + PC_STEP};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            q_mem_q    <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            q_mem_q    <= q_mem_d;
        end
    end

endmodule
